// File: rtl/magnitude_comparator_seq.sv
// Multi-cycle magnitude comparator: operands are captured on start and
// compared MSB-first, CHUNK bits per clock, stopping at the first chunk
// that differs. Signed operands are turned into offset-binary at capture
// (MSB inverted) so the chunk walk is always an unsigned compare.
module magnitude_comparator_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    CMP
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_r_q, a_r_d;
  logic [WIDTH-1:0] b_r_q, b_r_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic [CHUNK-1:0] a_chunk, b_chunk;

  // Select chunk idx (counted from the MSB end) of both latched operands.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_chunk = a_r_q[WIDTH-1-i*CHUNK -: CHUNK];
        b_chunk = b_r_q[WIDTH-1-i*CHUNK -: CHUNK];
      end
    end
  end

  // Next-state logic: capture in IDLE, walk chunks in CMP, decide on first difference.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_r_d   = a_r_q;
    b_r_d   = b_r_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_r_d = a;
          b_r_d = b;
          if (is_signed) begin
            a_r_d[WIDTH-1] = ~a[WIDTH-1];
            b_r_d[WIDTH-1] = ~b[WIDTH-1];
          end
          idx_d   = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (a_chunk != b_chunk) begin
          gt_d    = (a_chunk > b_chunk);
          lt_d    = (a_chunk < b_chunk);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (idx_q == IDXW'(N - 1)) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_r_q   <= '0;
      b_r_q   <= '0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_r_q   <= a_r_d;
      b_r_q   <= b_r_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy   = (state_q == CMP);
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;

endmodule

// File: doc/magnitude_comparator_seq.md
# magnitude_comparator_seq

Parametrised, multi-cycle magnitude comparator that generalises the single-bit comparator to WIDTH-bit operands with selectable signed/unsigned mode. Operands are captured on a start pulse and compared MSB-first, CHUNK bits per clock. The compare terminates early on the first differing chunk and posts registered gt/lt/eq flags with a one-cycle done strobe. It sits in the combinational-circuits library as the sequential, area-lean alternative to a flat wide comparator.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2 and a multiple of CHUNK.
- CHUNK, 2, bits compared per cycle; must be ≥ 1. Define N = WIDTH/CHUNK.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset.
  - One clock; reset is synchronous and active-high.
- start  input  1  request a compare; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle strobe; result flags are valid from this cycle onward.
- a_gt_b  output  1  registered result: A > B.
- a_lt_b  output  1  registered result: A < B.
- a_eq_b  output  1  registered result: A == B.

## Operation
- **States:** IDLE, CMP.
- **Capture (IDLE, start=1):**
  - Latch a_r = a and b_r = b.
  - If is_signed=1, invert the MSB of both latched copies (offset-binary), so all further comparison is unsigned.
  - Set idx = 0 and go to CMP.
- **CMP, each cycle:**
  - Compare chunk idx, i.e. bits [WIDTH-1-idx·CHUNK -: CHUNK] of a_r and b_r.
  - Chunks differ: set a_gt_b or a_lt_b from the unsigned chunk compare, clear the other two flags, pulse done, go to IDLE.
  - Chunks equal and idx == N-1: set a_eq_b=1, clear gt/lt, pulse done, go to IDLE.
  - Otherwise: idx += 1.
- **Flags:** exactly one of gt/lt/eq is high after any done. Flags hold their value until the next done or reset.
- **Busy behaviour:** start is ignored while busy=1. Input changes during CMP have no effect.
- **idx width:** max(1, clog2(N)). idx never wraps because the exit at N-1 is mandatory.
- **Reset:**
  - state=IDLE, idx=0, busy=0, done=0, a_gt_b=0, a_lt_b=0, a_eq_b=0.
  - All flags low means "no result yet".
  - Reset asserted mid-CMP aborts the compare: no done is issued and flags clear.
- **Reset and start together:** reset wins.

## Timing
- start is sampled at the edge ending cycle T. busy is high from cycle T+1.
- Chunk k is evaluated in cycle T+1+k.
- done and the updated flags appear in cycle T+2+k, where k is the deciding chunk index.
  - Best case: T+2.
  - Worst case (equal operands or last-chunk difference): T+1+N.
- busy falls in the same cycle done rises; done and busy are never high together.
- Back-to-back operation: start may be asserted in the done cycle, since the FSM is in IDLE. The next compare then begins one cycle later with no bubble beyond that.
- **CHUNK == WIDTH (N = 1):** every compare takes exactly 1 CMP cycle, so done is at T+2.

## Test plan
Use WIDTH=8, CHUNK=2 (N=4) unless stated.
1. **Early gt, unsigned:** a=0xA5, b=0x35, is_signed=0 → chunk 0 (10 vs 00) decides; done at T+2, a_gt_b=1, others 0.
2. **Equal, full latency:** a=0x5A, b=0x5A → done at T+5, a_eq_b=1. Then a=0x12, b=0x13 → decided at chunk 3; done at T+5, a_lt_b=1.
3. **Signed vs unsigned:** a=0x80, b=0x01.
   - is_signed=1 → a_lt_b=1 (−128 < 1), done at T+2.
   - is_signed=0 → a_gt_b=1.
   - Also a=0xFF, b=0xFE, is_signed=1 → a_gt_b=1, done at T+5.
4. **Ignored start and input hold:** assert start with a=0x00, b=0xFF while busy, and change a/b mid-CMP → the original compare completes with the original result. Only one done is issued per accepted start.
5. **Back-to-back and reset:**
   - Assert start in the done cycle → the second compare is accepted and its done is at the expected offset.
   - Assert rst during CMP → busy=0 and all flags 0 on the next cycle, with no done.
   - Assert rst together with start → no compare begins.
6. **Parameter sweep:** WIDTH=8 with CHUNK=1 and with CHUNK=8, and WIDTH=16 with CHUNK=4, run on 1000 random signed and unsigned pairs.
   - Flags must match a reference compare.
   - done latency must equal 2 + the index of the deciding chunk.
